// File: rtl/i2s_frame_sequencer.sv
// I2S SCLK/LRCLK generator with a double-buffered mono sample path to the serializer.
// data_out only changes at frame boundaries. Underruns either repeat or zero the sample, and they are counted.
module i2s_frame_sequencer #(
  parameter int SCLK_DIV         = 8,
  parameter int BITS_PER_CH      = 32,
  parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        run,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        SCLK,
  output logic        LRCLK,
  output logic [23:0] data_out,
  output logic        frame_start,
  output logic [15:0] underrun_cnt
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(2 * BITS_PER_CH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * BITS_PER_CH - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(BITS_PER_CH);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             frame_start_q, frame_start_d;
  logic [23:0]      data_q, data_d;
  logic [23:0]      pend_q, pend_d;
  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic [15:0]      ucnt_q, ucnt_d;

  logic div_tc, sclk_fall, boundary, xfer;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    div_d         = div_q;
    bit_d         = bit_q;
    sclk_d        = sclk_q;
    data_d        = data_q;
    pend_d        = pend_q;
    full_d        = full_q;
    ucnt_d        = ucnt_q;

    div_tc    = (div_q == DIV_LAST);
    sclk_fall = div_tc & sclk_q;
    boundary  = run & sclk_fall & (bit_q == BIT_LAST);
    xfer      = sample_valid & ready_q;

    if (!run) begin
      div_d  = '0;
      bit_d  = '0;
      sclk_d = 1'b0;
    end else begin
      div_d = div_tc ? '0 : div_q + 1'b1;
      if (div_tc)    sclk_d = ~sclk_q;
      if (sclk_fall) bit_d  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    end

    // Deriving LRCLK from the next bit count aligns it with the SCLK falling edge.
    lrclk_d       = (bit_d >= BIT_HALF);
    frame_start_d = boundary;

    if (boundary) begin
      if (full_q) begin
        data_d = pend_q;
        full_d = 1'b0;
      end else if (xfer) begin
        data_d = sample_in;
      end else begin
        data_d = HOLD_ON_UNDERRUN ? data_q : 24'd0;
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
      end
    end else if (xfer) begin
      pend_d = sample_in;
      full_d = 1'b1;
    end

    // Registering ready keeps sample_valid out of any combinational path to sample_ready.
    ready_d = ~full_d;
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge state.
    if (!RESET_N) begin
      div_q         <= '0;
      bit_q         <= '0;
      sclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      data_q        <= '0;
      pend_q        <= '0;
      full_q        <= 1'b0;
      ready_q       <= 1'b0;
      ucnt_q        <= '0;
    end else begin
      div_q         <= div_d;
      bit_q         <= bit_d;
      sclk_q        <= sclk_d;
      lrclk_q       <= lrclk_d;
      frame_start_q <= frame_start_d;
      data_q        <= data_d;
      pend_q        <= pend_d;
      full_q        <= full_d;
      ready_q       <= ready_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assign sample_ready = ready_q;
  assign SCLK         = sclk_q;
  assign LRCLK        = lrclk_q;
  assign data_out     = data_q;
  assign frame_start  = frame_start_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: doc/i2s_frame_sequencer.md
# i2s_frame_sequencer

Generates the I2S bit clock (SCLK) and word-select clock (LRCLK) from the 50 MHz system clock, and schedules delivery of mono 24-bit samples from the synth voice mixer to the I2S serializer. Samples arrive through a ready/valid handshake and are double-buffered. `data_out` changes only at frame boundaries, so the serializer sees one stable sample per frame. Missing samples (underruns) are handled deterministically and counted. The block sits between the mixer output and the serializer's `LRCLK`/`SCLK`/`data_in` inputs.

## Interface
- `SCLK_DIV`, default 8: SCLK half-period in CLK cycles (≥2). Default gives SCLK = 3.125 MHz.
- `BITS_PER_CH`, default 32: SCLK periods per channel (≥25). Default gives LRCLK = 48.83 kHz.
- `HOLD_ON_UNDERRUN`, default 1: on underrun, 1 = repeat the last sample; 0 = output zero.
- `CLK` in 1: 50 MHz system clock. Every register updates on its rising edge.
- `RESET_N` in 1: reset, synchronous, active-low.
- `run` in 1: 1 = clocks running; 0 = clocks held in their reset state.
- `sample_in` in 24: signed sample from the mixer.
- `sample_valid` in 1: `sample_in` is valid.
- `sample_ready` out 1: pending buffer is empty, so a sample can be accepted.
- `SCLK` out 1: I2S bit clock, registered.
- `LRCLK` out 1: word select, registered. 0 = left, 1 = right.
- `data_out` out 24: sample presented to the serializer.
- `frame_start` out 1: one-CLK pulse at each frame boundary.
- `underrun_cnt` out 16: saturating count of frames with no sample available.

## Operation
- Reset (`RESET_N`=0 at a CLK edge) forces:
  - `SCLK`=0, `LRCLK`=0, `data_out`=0, `frame_start`=0, `sample_ready`=0, `underrun_cnt`=0.
  - Pending buffer empty; `div_cnt`=0; `bit_cnt`=0.
- `sample_ready` goes to 1 on the first cycle after reset is released.
- Reset asserted mid-frame aborts the frame immediately. A pending sample is discarded.
- Clock divider:
  - `div_cnt` counts 0..`SCLK_DIV`-1 while `run`=1.
  - At terminal count, `div_cnt` wraps and `SCLK` toggles.
- Bit counter:
  - `bit_cnt` counts 0..2·`BITS_PER_CH`-1.
  - It advances on the cycle `SCLK` is toggled 1→0 (falling edge).
  - `LRCLK` is registered as (next `bit_cnt` ≥ `BITS_PER_CH`). It therefore changes only together with SCLK falling edges.
- Frame boundary: the cycle `bit_cnt` wraps from 2·`BITS_PER_CH`-1 to 0. On that cycle:
  - `LRCLK` goes 1→0 and `frame_start`=1.
  - If the pending buffer is full: `data_out` ← pending, and the buffer is emptied.
  - Else, if `sample_valid` is 1 on the same cycle: `data_out` ← `sample_in` directly (bypass). This is not an underrun.
  - Else (underrun): `data_out` ← `data_out` if `HOLD_ON_UNDERRUN`=1, else 0. `underrun_cnt` increments, saturating at 0xFFFF.
- Handshake:
  - A transfer occurs on any cycle with `sample_valid`=1 and `sample_ready`=1.
  - A transfer off the boundary cycle fills the pending buffer, and `sample_ready` drops the next cycle.
  - `sample_ready` rises the cycle after the pending buffer empties at a boundary.
  - A full buffer at a boundary consumes the pending sample only. A concurrent `sample_valid` is not accepted, because `sample_ready`=0.
- `run`=0:
  - Synchronously clears `div_cnt`, `bit_cnt`, `SCLK`, `LRCLK` on the next edge.
  - `data_out`, the pending buffer, the handshake and `underrun_cnt` are unaffected. No boundaries occur.
  - On return to `run`=1, the first frame starts at `bit_cnt`=0. The first boundary comes after one full frame.
- `data_out` is constant between boundaries under all conditions except reset.

## Timing
- SCLK period = 2·`SCLK_DIV` CLK cycles, with 50% duty.
- Frame = 2·`BITS_PER_CH` SCLK periods = 4·`SCLK_DIV`·`BITS_PER_CH` CLK cycles (1024 with defaults).
- The first SCLK rise occurs `SCLK_DIV` cycles after `run` rises (reset released, `run`=1).
- Sample acceptance to `data_out`:
  - Latency equals the time to the next boundary, plus 0 cycles in the register stage.
  - On a boundary, the new `data_out` is visible the cycle after that edge, together with the `LRCLK` fall.
- `frame_start`, `LRCLK` and `data_out` all change on the same CLK edge.
- `underrun_cnt` updates on the same edge as `frame_start`.
- `sample_ready` has no combinational path from `sample_valid`.

## Test plan
- Reset with defaults and `run`=1, release → `SCLK` first rises at cycle 8, period 16; `LRCLK` period 1024; `LRCLK` toggles only on SCLK falls.
- Feed 0x123456, then 0xABCDEF one frame later (each accepted mid-frame) → `data_out` = 0x123456 at boundary 1, 0xABCDEF at boundary 2; constant between boundaries; `underrun_cnt`=0.
- No sample in frame 3 with `HOLD_ON_UNDERRUN`=1 → `data_out` holds 0xABCDEF and `underrun_cnt`=1. Repeat with `HOLD_ON_UNDERRUN`=0 → `data_out`=0.
- Raise `sample_valid` with 0x000001 exactly on the boundary cycle while the buffer is empty → bypass: `data_out`=0x000001 next cycle, no underrun count.
- Hold `sample_valid` high continuously → exactly one acceptance per frame; `sample_ready` low from the accept+1 cycle until the boundary+1 cycle.
- Deassert `run` mid-frame for 100 cycles → `SCLK`/`LRCLK` go 0, no `frame_start`, `data_out` unchanged. Assert `RESET_N`=0 mid-frame with the buffer full → all outputs return to reset values and the pending sample is lost.
